instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Producer side of the decode interface: holds the PC and a word-addressed instruction
//  memory, and drives the IF/ID pipeline register whose inst_out feeds instruction_decode.
//  Supports stall, branch redirect from EX (beq resolution) and a fault state for bad PCs.
//  Instruction memory is loaded through a write port by the bench or boot logic.
// PARAMETERS
//  IMEM_DEPTH  256        number of 32-bit instruction words; power of 2, >=4
//  RESET_PC    64'h0      PC value after reset; must be 4-byte aligned and < IMEM_DEPTH*4
//  NOP_INST    32'h00000013  bubble instruction (addi x0,x0,0); decodes to all-zero controls
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  reset          in   1   asynchronous, active-high reset
//  stall          in   1   hold PC and IF/ID register (hazard from later stages)
//  branch_taken   in   1   redirect request from EX
//  branch_target  in   64  byte address of redirect target
//  imem_we        in   1   instruction memory write enable
//  imem_waddr     in   $clog2(IMEM_DEPTH)  word index to write
//  imem_wdata     in   32  instruction word to write
//  pc             out  64  current fetch PC
//  pc_out         out  64  PC of instruction held in IF/ID
//  inst_out       out  32  instruction held in IF/ID (to decode inst input)
//  inst_valid     out  1   IF/ID holds a real instruction (0 = bubble)
//  fault          out  1   sticky: fetch stopped on misaligned or out-of-range PC
// BEHAVIOUR
//  Reset (async assert, sync to next edge on release): pc=RESET_PC, pc_out=0,
//   inst_out=NOP_INST, inst_valid=0, fault=0, state=RUN. Memory contents not cleared.
//  States: RUN, FAULT. FAULT exits only via reset.
//  RUN, per rising edge, priority order:
//   1. branch_taken=1 (wins over stall): if branch_target[1:0]!=0 or target>=IMEM_DEPTH*4
//      -> state=FAULT, fault=1, pc unchanged; else pc<=branch_target.
//      Either way IF/ID <= bubble (inst_out=NOP_INST, inst_valid=0, pc_out=pc).
//   2. stall=1: pc, pc_out, inst_out, inst_valid all hold.
//   3. otherwise: pc_out<=pc, inst_out<=imem[pc[2+:log2(IMEM_DEPTH)]], inst_valid<=1,
//      pc<=pc+4.
//  Range: if pc+4 >= IMEM_DEPTH*4 on a normal advance, the current word is still issued,
//   then state=FAULT, fault=1, pc holds last in-range value (no wrap-around).
//  FAULT: pc holds; IF/ID <= bubble every cycle; stall/branch_taken ignored.
//  Fetch latency: instruction at PC p appears on inst_out one edge after pc==p with stall=0.
//  Memory write: imem[imem_waddr]<=imem_wdata on rising edge, any state, not affected by
//   reset. Same-cycle write and fetch of same word: fetch returns OLD word.
//  PC arithmetic is 64-bit unsigned; upper bits beyond index compared, never truncated.
// TESTING
//  T1 reset, load words 0..3 = ld/sd/add/beq encodings, run -> inst_out in order on
//     cycles 1..4, pc_out=0,4,8,12, inst_valid=1 from cycle 1.
//  T2 stall high 3 cycles while inst_out=word1 (pc=8) -> inst_out, pc_out=4, pc=8 held;
//     release -> word2 next edge.
//  T3 branch_taken=1, target=0x4, together with stall=1 -> next edge inst_valid=0,
//     inst_out=0x00000013, pc=4; following edge inst_out=word1, pc_out=4.
//  T4 branch_target=0x6 -> fault=1, inst_valid=0 forever, pc unchanged; reset clears fault.
//  T5 IMEM_DEPTH=4, run linearly -> word3 issued at pc_out=12, then fault=1, pc=12, no wrap.
//  T6 imem_we to word at current pc same cycle as fetch -> old word issued; re-fetch via
//     branch gets new word. Assert reset mid-run -> outputs at reset values immediately.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, word-addressed instruction memory and the IF/ID register
// feeding decode. Branch redirects from EX; bad PCs park the stage in a sticky FAULT.
module instruction_fetch #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          branch_taken,
  input  logic [63:0]                   branch_target,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [63:0]                   pc,
  output logic [63:0]                   pc_out,
  output logic [31:0]                   inst_out,
  output logic                          inst_valid,
  output logic                          fault
);

  localparam int unsigned AW       = $clog2(IMEM_DEPTH);
  localparam logic [63:0] PC_LIMIT = 64'(IMEM_DEPTH) << 2;

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state, state_n;
  logic [63:0] pc_n, pc_out_n, pc_inc;
  logic [31:0] inst_n;
  logic        valid_n;
  logic        target_bad;

  logic [31:0] imem [IMEM_DEPTH];

  // Memory is never reset; reads below see the pre-write word on a same-edge write.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  assign pc_inc     = pc + 64'd4;
  assign target_bad = (branch_target[1:0] != 2'b00) || (branch_target >= PC_LIMIT);
  assign fault      = (state == FAULT);

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    pc_out_n = pc_out;
    inst_n   = inst_out;
    valid_n  = inst_valid;
    case (state)
      RUN: begin
        if (branch_taken) begin
          pc_out_n = pc;
          inst_n   = NOP_INST;
          valid_n  = 1'b0;
          if (target_bad) state_n = FAULT;
          else            pc_n    = branch_target;
        end else if (!stall) begin
          pc_out_n = pc;
          inst_n   = imem[pc[2 +: AW]];
          valid_n  = 1'b1;
          // Last word is still issued; PC never wraps past the end of memory.
          if (pc_inc >= PC_LIMIT) state_n = FAULT;
          else                    pc_n    = pc_inc;
        end
      end
      FAULT: begin
        pc_out_n = pc;
        inst_n   = NOP_INST;
        valid_n  = 1'b0;
      end
      default: state_n = FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      pc         <= RESET_PC;
      pc_out     <= 64'h0;
      inst_out   <= NOP_INST;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pc_out     <= pc_out_n;
      inst_out   <= inst_n;
      inst_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a 256-word and a 4-word instance, each shadowed by a
// rule-level model, plus directed literal checks of the documented scenarios.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'h0000_3083; // ld  x1,0(x0)
  localparam logic [31:0] W1  = 32'h0010_3423; // sd  x1,8(x0)
  localparam logic [31:0] W2  = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] W3  = 32'h0020_8463; // beq x1,x2,8
  localparam logic [31:0] NEWW = 32'hDEAD_BEEF;

  logic        clk = 1'b0, reset = 1'b1;
  logic        stall = 0, br = 0, we = 0;
  logic [63:0] tgt = 0;
  logic [7:0]  waddr = 0;
  logic [31:0] wdata = 0;
  logic        stall4 = 0, br4 = 0, we4 = 0;
  logic [63:0] tgt4 = 0;
  logic [1:0]  waddr4 = 0;
  logic [31:0] wdata4 = 0;

  logic [63:0] pc, pc_out, pc4, pc_out4;
  logic [31:0] inst_out, inst_out4;
  logic        inst_valid, fault, inst_valid4, fault4;

  int pass_cnt = 0, tot_cnt = 0;

  instruction_fetch #(.IMEM_DEPTH(256)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(br), .branch_target(tgt),
    .imem_we(we), .imem_waddr(waddr), .imem_wdata(wdata),
    .pc(pc), .pc_out(pc_out), .inst_out(inst_out), .inst_valid(inst_valid), .fault(fault));

  instruction_fetch #(.IMEM_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall4), .branch_taken(br4), .branch_target(tgt4),
    .imem_we(we4), .imem_waddr(waddr4), .imem_wdata(wdata4),
    .pc(pc4), .pc_out(pc_out4), .inst_out(inst_out4), .inst_valid(inst_valid4), .fault(fault4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model: architectural rules, not RTL structure ----------------
  typedef struct {
    logic [63:0] pc, pc_out;
    logic [31:0] inst;
    bit          valid, fault;
  } mst_t;

  localparam mst_t M_RST = '{pc: 64'h0, pc_out: 64'h0, inst: NOP, valid: 1'b0, fault: 1'b0};

  mst_t m = M_RST, m4 = M_RST;
  logic [31:0] mem [256];
  logic [31:0] mem4 [4];

  function automatic mst_t step(mst_t s, bit stl, bit b, logic [63:0] t,
                                logic [31:0] word, logic [63:0] lim);
    mst_t n = s;
    if (s.fault || b) begin
      n.pc_out = s.pc; n.inst = NOP; n.valid = 0;
      if (!s.fault) begin
        if (t % 4 != 0 || t >= lim) n.fault = 1;
        else n.pc = t;
      end
    end else if (!stl) begin
      n.pc_out = s.pc; n.inst = word; n.valid = 1;
      if (s.pc + 4 >= lim) n.fault = 1;
      else n.pc = s.pc + 4;
    end
    return n;
  endfunction

  // Reset is only ever raised while clk is low, so clk==1 marks a real clock edge.
  always @(posedge clk or posedge reset) begin
    logic [31:0] wd, wd4;
    wd  = (m.pc  < 64'd1024) ? mem[int'(m.pc >> 2)]  : 32'h0;
    wd4 = (m4.pc < 64'd16)   ? mem4[int'(m4.pc >> 2)] : 32'h0;
    if (reset) begin
      m = M_RST; m4 = M_RST;
    end else begin
      m  = step(m,  stall,  br,  tgt,  wd,  64'd1024);
      m4 = step(m4, stall4, br4, tgt4, wd4, 64'd16);
    end
    if (clk && we)  mem[waddr]   = wdata;
    if (clk && we4) mem4[waddr4] = wdata4;
  end

  always begin
    @(posedge clk); #2;
    chk("m.pc", pc, m.pc);           chk("m.pc_out", pc_out, m.pc_out);
    chk("m.inst", 64'(inst_out), 64'(m.inst));
    chk("m.valid", 64'(inst_valid), 64'(m.valid));
    chk("m.fault", 64'(fault), 64'(m.fault));
    chk("m4.pc", pc4, m4.pc);        chk("m4.pc_out", pc_out4, m4.pc_out);
    chk("m4.inst", 64'(inst_out4), 64'(m4.inst));
    chk("m4.valid", 64'(inst_valid4), 64'(m4.valid));
    chk("m4.fault", 64'(fault4), 64'(m4.fault));
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic nxt(); @(negedge clk); endtask

  task automatic chk_if(input string n, input logic [31:0] i, input logic [63:0] po,
                        input logic v, input logic [63:0] p);
    chk({n, ".inst"}, 64'(inst_out), 64'(i));
    chk({n, ".pc_out"}, pc_out, po);
    chk({n, ".valid"}, 64'(inst_valid), 64'(v));
    chk({n, ".pc"}, pc, p);
  endtask

  function automatic logic [31:0] word_of(int i);
    case (i)
      0: return W0; 1: return W1; 2: return W2; 3: return W3;
      default: return 32'h1000_0000 + 32'(i);
    endcase
  endfunction

  initial begin
    // load both memories while reset is held
    for (int i = 0; i < 256; i++) begin
      nxt();
      we = 1; waddr = 8'(i); wdata = word_of(i);
      we4 = (i < 4); waddr4 = 2'(i); wdata4 = 32'hAAAA_0000 + 32'(i);
    end
    nxt(); we = 0; we4 = 0;
    chk_if("rst", NOP, 64'h0, 1'b0, 64'h0);
    chk("rst.fault", 64'(fault), 64'h0);
    reset = 0;

    // T1: in-order issue
    nxt(); chk_if("t1.c1", W0, 64'h0, 1'b1, 64'h4);
    nxt(); chk_if("t1.c2", W1, 64'h4, 1'b1, 64'h8);
    // T2: stall holds everything
    stall = 1;
    for (int k = 0; k < 3; k++) begin nxt(); chk_if("t2.hold", W1, 64'h4, 1'b1, 64'h8); end
    stall = 0;
    nxt(); chk_if("t2.rel", W2, 64'h8, 1'b1, 64'hC);
    // T3: branch wins over stall
    br = 1; tgt = 64'h4; stall = 1;
    nxt(); chk_if("t3.bub", NOP, 64'hC, 1'b0, 64'h4);
    br = 0; stall = 0;
    nxt(); chk_if("t3.tgt", W1, 64'h4, 1'b1, 64'h8);
    // T4: misaligned target faults, sticky
    br = 1; tgt = 64'h6;
    nxt(); chk_if("t4.f", NOP, 64'h8, 1'b0, 64'h8); chk("t4.fault", 64'(fault), 64'h1);
    tgt = 64'h0;
    for (int k = 0; k < 3; k++) begin
      stall = k[0];
      nxt(); chk_if("t4.stick", NOP, 64'h8, 1'b0, 64'h8); chk("t4.stickf", 64'(fault), 64'h1);
    end
    br = 0; stall = 0;
    reset = 1; #1;
    chk_if("t4.rst", NOP, 64'h0, 1'b0, 64'h0); chk("t4.rstf", 64'(fault), 64'h0);
    nxt(); reset = 0;

    // T6: same-edge write returns old word; re-fetch sees new
    we = 1; waddr = 8'h0; wdata = NEWW;
    nxt(); chk_if("t6.old", W0, 64'h0, 1'b1, 64'h4);
    we = 0; br = 1; tgt = 64'h0;
    nxt(); chk_if("t6.bub", NOP, 64'h4, 1'b0, 64'h0);
    br = 0;
    nxt(); chk_if("t6.new", NEWW, 64'h0, 1'b1, 64'h4);
    // target differing only above the index bits must fault
    br = 1; tgt = 64'h1_0000_0000;
    nxt(); chk("hi.fault", 64'(fault), 64'h1); chk("hi.pc", pc, 64'h4);
    br = 0;

    // T5: 4-word instance runs off the end without wrapping
    reset = 1; nxt(); reset = 0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("t5.pc_out", pc_out4, 64'(4 * i));
      chk("t5.inst", 64'(inst_out4), 64'(32'hAAAA_0000 + 32'(i)));
      chk("t5.valid", 64'(inst_valid4), 64'h1);
    end
    chk("t5.fault", 64'(fault4), 64'h1); chk("t5.pc", pc4, 64'hC);
    nxt(); chk("t5.bub", 64'(inst_valid4), 64'h0); chk("t5.nowrap", pc4, 64'hC);

    // out-of-range target on small instance; last in-range word on large one
    reset = 1; nxt(); reset = 0;
    br = 1; tgt = 64'h3FC; br4 = 1; tgt4 = 64'h10;
    nxt(); chk("oor.fault4", 64'(fault4), 64'h1); chk("oor.pc4", pc4, 64'h0);
    chk("last.pc", pc, 64'h3FC); chk("last.nofault", 64'(fault), 64'h0);
    br = 0; br4 = 0;
    nxt(); chk_if("last.issue", 32'h1000_00FF, 64'h3FC, 1'b1, 64'h3FC);
    chk("last.fault", 64'(fault), 64'h1);

    nxt(); nxt();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
